// File: rtl/zx_cmd_port_if.sv
// rtl/zx_cmd_port_if.sv - Z80 bus and loader command handshake signals for zx_cmd_port
interface zx_cmd_port_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_m1_n;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_oe;
  logic [7:0]  cmd;
  logic        cmd_en;
  logic        cmd_ack;
  logic        busy;

  // master drives the Z80 bus and the loader ack; slave is the command port itself
  modport master (
    output cpu_addr, cpu_din, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cmd_ack,
    input  cpu_dout, cpu_dout_oe, cmd, cmd_en, busy
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cmd_ack,
    output cpu_dout, cpu_dout_oe, cmd, cmd_en, busy
  );
endinterface

// File: rtl/zx_cmd_port.sv
// rtl/zx_cmd_port.sv - Z80 I/O command port driving the loader cmd/cmd_en/cmd_ack handshake
module zx_cmd_port #(
  parameter logic [15:0] PORT_ADDR      = 16'h00E3,
  parameter logic [15:0] ADDR_MASK      = 16'h00FF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic          clk,
  input  logic          reset,
  zx_cmd_port_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_en_q, cmd_en_d;
  logic [23:0] tcnt_q, tcnt_d;
  logic        err_to_q, err_to_d;
  logic        err_ovr_q, err_ovr_d;
  logic        done_q, done_d;
  logic        wr_cond_q, wr_cond_d;
  logic        rd_cond_q, rd_cond_d;
  logic        busy_q, busy_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;

  logic hit;
  logic wr_cond;
  logic rd_cond;
  logic wr_evt;
  logic rd_end;
  logic timeout_hit;

  // M1 low with IORQ low is an interrupt acknowledge, never a port access
  assign hit = ((bus.cpu_addr & ADDR_MASK) == (PORT_ADDR & ADDR_MASK))
             & ~bus.cpu_iorq_n & bus.cpu_m1_n;
  assign wr_cond = hit & ~bus.cpu_wr_n;
  assign rd_cond = hit & ~bus.cpu_rd_n;

  assign wr_cond_d = wr_cond;
  assign rd_cond_d = rd_cond;
  assign wr_evt    = wr_cond & ~wr_cond_q;
  assign rd_end    = ~rd_cond & rd_cond_q;

  assign timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (tcnt_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      cmd_en_q   <= 1'b0;
      tcnt_q     <= 24'd0;
      err_to_q   <= 1'b0;
      err_ovr_q  <= 1'b0;
      done_q     <= 1'b0;
      wr_cond_q  <= 1'b0;
      rd_cond_q  <= 1'b0;
      busy_q     <= 1'b0;
      cpu_dout_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_en_q   <= cmd_en_d;
      tcnt_q     <= tcnt_d;
      err_to_q   <= err_to_d;
      err_ovr_q  <= err_ovr_d;
      done_q     <= done_d;
      wr_cond_q  <= wr_cond_d;
      rd_cond_q  <= rd_cond_d;
      busy_q     <= busy_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_evt) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.cmd_ack) begin
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!bus.cmd_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d     = cmd_q;
    cmd_en_d  = cmd_en_q;
    tcnt_d    = tcnt_q;
    err_to_d  = err_to_q;
    err_ovr_d = err_ovr_q;
    done_d    = done_q;

    // clears come first so any set below in the same cycle wins
    if (rd_end) begin
      err_to_d  = 1'b0;
      err_ovr_d = 1'b0;
      done_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_evt) begin
          cmd_d    = bus.cpu_din;
          cmd_en_d = 1'b1;
          tcnt_d   = 24'd0;
          done_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (wr_evt) begin
          err_ovr_d = 1'b1;
        end
        if (bus.cmd_ack) begin
          cmd_en_d = 1'b0;
        end else if (timeout_hit) begin
          cmd_en_d = 1'b0;
          err_to_d = 1'b1;
        end else if (tcnt_q != 24'hFF_FFFF) begin
          tcnt_d = tcnt_q + 24'd1;
        end
      end
      ST_RELEASE: begin
        if (wr_evt) begin
          err_ovr_d = 1'b1;
        end
        cmd_en_d = 1'b0;
        if (!bus.cmd_ack) begin
          done_d = 1'b1;
        end
      end
      default: begin
        cmd_en_d = 1'b0;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    cpu_dout_d = {busy_d, err_to_d, err_ovr_d, 4'b0000, done_d};
  end

  assign bus.cmd         = cmd_q;
  assign bus.cmd_en      = cmd_en_q;
  assign bus.busy        = busy_q;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.cpu_dout_oe = rd_cond;

endmodule

// File: tb/tb_zx_cmd_port.sv
// tb/tb_zx_cmd_port.sv - directed scoreboard bench for zx_cmd_port
module tb_zx_cmd_port;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [7:0] cmd_exp_q[$];
  logic [7:0] sts_exp_q[$];

  zx_cmd_port_if bus ();

  zx_cmd_port #(
    .PORT_ADDR      (16'h00E3),
    .ADDR_MASK      (16'h00FF),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
  endtask

  task automatic wr_start(input logic [15:0] addr, input logic [7:0] data);
    bus.cpu_addr   = addr;
    bus.cpu_din    = data;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
  endtask

  task automatic chk_cmd_issue(input string tag);
    logic [7:0] e;
    chk({tag, "_cmd_en"}, {31'd0, bus.cmd_en}, 32'd1);
    if (cmd_exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = cmd_exp_q.pop_front();
      chk({tag, "_cmd"}, {24'd0, bus.cmd}, {24'd0, e});
    end
  endtask

  task automatic status_read(input string tag);
    logic [7:0] e;
    bus.cpu_addr   = 16'h00E3;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    #1;
    chk({tag, "_oe"}, {31'd0, bus.cpu_dout_oe}, 32'd1);
    tick();
    e = (sts_exp_q.size() != 0) ? sts_exp_q.pop_front() : 8'hXX;
    chk({tag, "_status"}, {24'd0, bus.cpu_dout}, {24'd0, e});
    bus_idle();
    tick();
  endtask

  task automatic ack_pulse();
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
    tick();
  endtask

  initial begin
    int rises;
    int hi;
    logic prev;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_din  = 8'h00;
    bus.cmd_ack  = 1'b0;
    bus_idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_cmd_en", {31'd0, bus.cmd_en}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_dout", {24'd0, bus.cpu_dout}, 32'h00);
    chk("rst_cmd", {24'd0, bus.cmd}, 32'h00);
    chk("rst_oe", {31'd0, bus.cpu_dout_oe}, 32'd0);

    // basic command with delayed ack
    cmd_exp_q.push_back(8'h42);
    wr_start(16'h00E3, 8'h42);
    tick();
    chk_cmd_issue("t1");
    bus_idle();
    repeat (3) tick();
    chk("t1_hold_cmd_en", {31'd0, bus.cmd_en}, 32'd1);
    bus.cmd_ack = 1'b1;
    tick();
    chk("t1_ack_cmd_en", {31'd0, bus.cmd_en}, 32'd0);
    chk("t1_ack_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.cmd_ack = 1'b0;
    tick();
    chk("t1_rel_busy", {31'd0, bus.busy}, 32'd0);
    sts_exp_q.push_back(8'h01);
    status_read("t1_rd1");
    sts_exp_q.push_back(8'h00);
    status_read("t1_rd2");

    // long write strobe yields one request
    cmd_exp_q.push_back(8'h33);
    wr_start(16'h00E3, 8'h33);
    rises = 0;
    prev  = bus.cmd_en;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cmd_en && !prev) begin
        rises++;
        if (rises == 1) chk_cmd_issue("t2");
      end
      prev = bus.cmd_en;
    end
    bus_idle();
    chk("t2_rises", rises, 1);
    ack_pulse();
    chk("t2_busy", {31'd0, bus.busy}, 32'd0);
    sts_exp_q.push_back(8'h01);
    status_read("t2_rd");

    // timeout with no ack
    cmd_exp_q.push_back(8'h77);
    wr_start(16'h00E3, 8'h77);
    tick();
    chk_cmd_issue("t3");
    bus_idle();
    hi = 0;
    while (bus.cmd_en && hi < 100) begin
      hi++;
      tick();
    end
    chk("t3_cmd_en_cycles", hi, 16);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    sts_exp_q.push_back(8'h40);
    status_read("t3_rd1");
    sts_exp_q.push_back(8'h00);
    status_read("t3_rd2");

    // overrun while busy
    cmd_exp_q.push_back(8'h42);
    wr_start(16'h00E3, 8'h42);
    tick();
    chk_cmd_issue("t4");
    bus_idle();
    tick();
    wr_start(16'h00E3, 8'h55);
    tick();
    bus_idle();
    tick();
    chk("t4_cmd_kept", {24'd0, bus.cmd}, 32'h42);
    chk("t4_dout_busy", {24'd0, bus.cpu_dout}, 32'hA0);
    ack_pulse();
    chk("t4_dout_done", {24'd0, bus.cpu_dout}, 32'h21);
    sts_exp_q.push_back(8'h21);
    status_read("t4_rd1");
    sts_exp_q.push_back(8'h00);
    status_read("t4_rd2");

    // address miss and interrupt acknowledge
    wr_start(16'h00E2, 8'h11);
    tick();
    tick();
    chk("t5_miss_cmd_en", {31'd0, bus.cmd_en}, 32'd0);
    chk("t5_miss_busy", {31'd0, bus.busy}, 32'd0);
    bus_idle();
    tick();
    bus.cpu_addr   = 16'h00E3;
    bus.cpu_m1_n   = 1'b0;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    #1;
    chk("t5_inta_oe", {31'd0, bus.cpu_dout_oe}, 32'd0);
    tick();
    tick();
    chk("t5_inta_cmd_en", {31'd0, bus.cmd_en}, 32'd0);
    bus_idle();
    tick();

    // reset during a pending request
    cmd_exp_q.push_back(8'h99);
    wr_start(16'h00E3, 8'h99);
    tick();
    chk_cmd_issue("t6a");
    bus_idle();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_cmd_en", {31'd0, bus.cmd_en}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_dout", {24'd0, bus.cpu_dout}, 32'h00);
    reset = 1'b0;
    tick();
    cmd_exp_q.push_back(8'h5A);
    wr_start(16'h00E3, 8'h5A);
    tick();
    chk_cmd_issue("t6b");
    bus_idle();
    ack_pulse();
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    sts_exp_q.push_back(8'h01);
    status_read("t6_rd");

    chk("sb_cmd_left", cmd_exp_q.size(), 0);
    chk("sb_sts_left", sts_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
